mult_share_arb: RTL
===================

// Module: mult_share_arb
// PURPOSE
//  Shares one pipelined WIDTH x WIDTH multiplier between N_REQ requesters.
//  Arbitration is round-robin. Each requester has a valid/ready request port and a response pulse.
//  Sits between the datapath clients and the mult_pipe datapath.
//  Sustains one issue per cycle, with at most one operation outstanding per requester.
// PARAMETERS
//  N_REQ    4   number of requesters (>=2)
//  WIDTH    32  operand/result width; result is low WIDTH bits of a*b (unsigned)
//  MUL_LAT  2   cycles from accept edge to rsp_valid (>=1)
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             synchronous, active-high reset
//  req_valid  in   N_REQ         requester i has an operation pending
//  req_ready  out  N_REQ         one-hot (or zero) grant; accept = valid & ready
//  req_a      in   N_REQ*WIDTH   operand a, slice i for requester i
//  req_b      in   N_REQ*WIDTH   operand b, slice i for requester i
//  rsp_valid  out  N_REQ         one-cycle pulse, result for requester i
//  rsp_data   out  WIDTH         result; meaningful only while |rsp_valid
//  busy       out  N_REQ         requester i has an op in flight
// BEHAVIOUR
//  Reset (sync, rst=1 at edge):
//   - pipe valid bits, busy, rsp_valid, rsp_data cleared to 0; rr pointer set to 0.
//   - In-flight ops are discarded; no rsp is produced for them.
//   - req_ready is 0 while rst=1.
//  Eligibility: elig[i] = req_valid[i] & ~busy[i].
//  Grant (combinational from elig and ptr):
//   - Winner = first eligible index scanning ptr, ptr+1, ... mod N_REQ.
//   - req_ready[winner] = 1; all other bits 0. No eligible requester -> req_ready = 0.
//  On accept of requester g:
//   - ptr <= (g+1) mod N_REQ, wrapping N_REQ-1 -> 0. No accept -> ptr holds.
//   - busy[g] <= 1.
//   - {a, b, tag=g} enter stage 0 of mult_pipe.
//  Latency: accept at edge k -> rsp_valid[g]=1 and rsp_data valid in the cycle after edge k+MUL_LAT-1,
//   i.e. registered output MUL_LAT edges after accept. Back-to-back accepts give back-to-back rsps.
//  Response: rsp_valid is a pulse with no backpressure; the requester must sample it.
//   At most one rsp_valid bit is set per cycle.
//  busy[g] clears on the edge that raises rsp_valid[g].
//   - g is therefore eligible again in the rsp cycle and can be re-accepted in that same cycle.
//  Requester behaviour:
//   - Requester must hold req_a/req_b stable while valid & ~ready.
//   - Requester may drop valid before accept; no op is issued in that case.
//  Simultaneous events:
//   - Accept of h and rsp to g in the same cycle are independent.
//   - If g==h (re-accept during rsp cycle), busy[g] ends 1.
//  Arithmetic: product is {WIDTH{0}}-extended inputs multiplied, truncated to WIDTH; overflow is silent.
//   Example: 0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  No combinational path from req_a/req_b to any output.
// STRUCTURE
//  mult_pkg:
//   - TAG_W = $clog2(N_REQ) (min 1).
//   - Default WIDTH/MUL_LAT localparams.
//   - rr_pick function (rotate-priority one-hot select).
//  Sub-module mult_pipe #(WIDTH, MUL_LAT, TAG_W):
//   - in_valid, a, b, tag -> out_valid, p, out_tag.
//   - Shift-register valid/tag; product computed in stage 0, registered through MUL_LAT stages.
//   - Sync reset clears valid bits only.
//  Top-level: arbiter, ptr, busy vector, and rsp decode (out_tag -> one-hot rsp_valid).
// TESTING
//  1. Single op: rst, req_valid=0001, a=6, b=7
//     -> req_ready=0001 same cycle; rsp_valid=0001, rsp_data=42 after MUL_LAT edges; busy 0001 then 0000.
//  2. Round-robin: all 4 valid continuously, operands a=i+1, b=10
//     -> grants 0,1,2,3 on consecutive cycles; rsps 10,20,30,40 in order; 5th grant returns to 0 only after busy[0] clears.
//  3. Wrap/ptr: after grant to 3, requesters 0 and 2 valid -> grant 0 first, then 2.
//  4. Truncation: a=0xFFFFFFFF, b=0xFFFFFFFF -> rsp_data=0x00000001; a=0x10000, b=0x10000 -> 0x00000000.
//  5. Re-accept in rsp cycle: requester 1 valid continuously
//     -> new accept coincides with each rsp_valid[1]; throughput 1 op per MUL_LAT cycles; busy[1] stays 1.
//  6. Reset mid-flight: accept ops for 0 and 2, assert rst 1 cycle before their rsp
//     -> no rsp_valid ever pulses for them; busy=0, ptr=0, next valid on 3 and 0 grants 0 first.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types, defaults and the rotate-priority picker for the multiplier-sharing arbiter.
package mult_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MUL_LAT = 2;
  localparam int MAX_REQ     = 32;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot pick of the first set bit of elig scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                                 input logic [4:0]         ptr,
                                                 input logic [5:0]         n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [5:0]         idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 6'(ptr) + 6'(k);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if (!found && (6'(k) < n) && elig[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Pipelined unsigned multiplier carrying a requester tag alongside the product.
// pre_valid/pre_tag expose what the final stage will load on the next edge.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] p,
  output logic [TAG_W-1:0] out_tag,
  output logic             pre_valid,
  output logic [TAG_W-1:0] pre_tag
);

  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q  [MUL_LAT];
  logic [TAG_W-1:0]   tag_d  [MUL_LAT];
  logic [WIDTH-1:0]   prod_q [MUL_LAT];
  logic [WIDTH-1:0]   prod_d [MUL_LAT];

  // Stage 0 forms the truncated product; later stages just shift.
  always_comb begin
    vld_d[0]  = in_valid;
    tag_d[0]  = tag;
    prod_d[0] = a * b;
    for (int s = 1; s < MUL_LAT; s++) begin
      vld_d[s]  = vld_q[s-1];
      tag_d[s]  = tag_q[s-1];
      prod_d[s] = prod_q[s-1];
    end
  end

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Tag and product payload registers.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    prod_q <= prod_d;
  end

  assign out_valid = vld_q[MUL_LAT-1];
  assign p         = prod_q[MUL_LAT-1];
  assign out_tag   = tag_q[MUL_LAT-1];
  assign pre_valid = vld_d[MUL_LAT-1];
  assign pre_tag   = tag_d[MUL_LAT-1];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters,
// with at most one operation in flight per requester.
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [N_REQ-1:0]       busy
);

  localparam int TAG_W = tag_w(N_REQ);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] busy_q, busy_d;
  logic [N_REQ-1:0] elig_s, grant_s;
  logic             accept_s;
  logic [TAG_W-1:0] gidx_s;
  logic [WIDTH-1:0] a_sel_s, b_sel_s;
  logic             out_valid_s, pre_valid_s;
  logic [TAG_W-1:0] out_tag_s, pre_tag_s;
  logic [WIDTH-1:0] p_s;

  // Grant selection and operand steering for the winning requester.
  always_comb begin
    elig_s  = req_valid & ~busy_q;
    gidx_s  = '0;
    a_sel_s = '0;
    b_sel_s = '0;
    if (rst) begin
      grant_s = '0;
    end else begin
      grant_s = N_REQ'(rr_pick(MAX_REQ'(elig_s), 5'(ptr_q), 6'(N_REQ)));
    end
    accept_s = |grant_s;
    for (int i = 0; i < N_REQ; i++) begin
      a_sel_s = a_sel_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      b_sel_s = b_sel_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      if (grant_s[i]) begin
        gidx_s = TAG_W'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  // Busy clears when the response is raised; a same-edge accept of the same requester wins.
  always_comb begin
    busy_d = busy_q;
    ptr_d  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (pre_valid_s && (pre_tag_s == TAG_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
    if (accept_s) begin
      busy_d = busy_d | grant_s;
      ptr_d  = (gidx_s == TAG_W'(N_REQ - 1)) ? '0 : gidx_s + TAG_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Arbiter pointer and busy vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  mult_pipe #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_s),
    .a         (a_sel_s),
    .b         (b_sel_s),
    .tag       (gidx_s),
    .out_valid (out_valid_s),
    .p         (p_s),
    .out_tag   (out_tag_s),
    .pre_valid (pre_valid_s),
    .pre_tag   (pre_tag_s)
  );

  // Tag decode of the final pipe stage into the one-hot response pulse.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (out_valid_s && (out_tag_s == TAG_W'(i))) begin
        rsp_valid[i] = 1'b1;
      end else begin
        rsp_valid[i] = 1'b0;
      end
    end
    rsp_data = out_valid_s ? p_s : '0;
  end

  assign req_ready = grant_s;
  assign busy      = busy_q;

endmodule
